// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the Ethernet test-frame generator.
// FRAME_GEN_VLAN_EN selects the 18-byte tagged header.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_PAY,
    ST_GAP
  } state_t;

  localparam int DEF_MIN_PAYLOAD = 46;
  localparam int DEF_MAX_PAYLOAD = 1500;
  localparam int DEF_JUMBO_MAX   = 9000;

  localparam logic [15:0] TPID     = 16'h8100;
  localparam logic [15:0] OPT_IPV4 = 16'h0800;
  localparam logic [15:0] OPT_ARP  = 16'h0806;
  localparam logic [15:0] OPT_RARP = 16'h8035;
  localparam logic [15:0] OPT_IPV6 = 16'h86DD;

`ifdef FRAME_GEN_VLAN_EN
  localparam int HDR_LEN = 18;
`else
  localparam int HDR_LEN = 14;
`endif

endpackage

// File: rtl/frame_gen_if.sv
// Byte-wide client port towards gig_eth_mac_tx.
// master = frame generator, slave = MAC.
interface frame_gen_if;

  logic       conf_tx_en;
  logic       conf_tx_jumbo_en;
  logic       conf_tx_no_gen_crc;
  logic [7:0] mac_tx_data;
  logic       mac_tx_dvld;
  logic       mac_tx_ack;

  modport master (
    output conf_tx_en,
    output conf_tx_jumbo_en,
    output conf_tx_no_gen_crc,
    output mac_tx_data,
    output mac_tx_dvld,
    input  mac_tx_ack
  );

  modport slave (
    input  conf_tx_en,
    input  conf_tx_jumbo_en,
    input  conf_tx_no_gen_crc,
    input  mac_tx_data,
    input  mac_tx_dvld,
    output mac_tx_ack
  );

endinterface

// File: rtl/frame_gen_ifg_timer.sv
// Inter-frame gap down-counter; done once one cycle
// or fewer remain, so a zero gap still costs one cycle.
module frame_gen_ifg_timer
  import frame_gen_pkg::*;
#(
  parameter int IFG_W = 16
) (
  input  logic             tx_clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [IFG_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [IFG_W-1:0] cnt;

  assign done = (cnt <= IFG_W'(1));

  always_ff @(posedge tx_clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !done) begin
      cnt <= cnt - IFG_W'(1);
    end
  end

endmodule

// File: rtl/frame_gen_param.sv
// Ethernet test-frame generator for the MAC TX client port.
// Define FRAME_GEN_VLAN_EN to add vlan_tci and an 802.1Q tag.
module frame_gen_param
  import frame_gen_pkg::*;
#(
  parameter logic [47:0] SRC_MAC = 48'h004e46324300,
  parameter int LEN_W       = 14,
  parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD,
  parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
  parameter int JUMBO_MAX   = DEF_JUMBO_MAX,
  parameter int IFG_W       = 16,
  parameter int SEQ_W       = 32
) (
  input  logic             tx_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont_mode,
  input  logic             jumbo_en,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [IFG_W-1:0] ifg_cycles,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  input  logic             src_mac_sel,
  input  logic [15:0]      ethertype,
`ifdef FRAME_GEN_VLAN_EN
  input  logic [15:0]      vlan_tci,
`endif
  input  logic [31:0]      timestamp,
  frame_gen_if.master      mac,
  output logic             busy,
  output logic [31:0]      frame_count
);

  localparam int CW = LEN_W + 1;
  localparam int HB = HDR_LEN * 8;

  state_t           st;
  logic [CW-1:0]    pos;
  logic [CW-1:0]    total_q;
  logic [CW-1:0]    nxt;
  logic [CW-1:0]    pi;
  logic [HB-1:0]    hdr_q;
  logic [HB-1:0]    hdr_d;
  logic [47:0]      src_eff;
  logic [SEQ_W-1:0] seq;
  logic [31:0]      ts_q;
  logic [31:0]      fc_q;
  logic [IFG_W-1:0] ifg_q;
  logic [7:0]       hbyte;
  logic [7:0]       sbyte;
  logic [7:0]       tbyte;
  logic [7:0]       nbyte;
  logic [7:0]       data_q;
  logic             dvld_q;
  logic             en_q;
  logic             jumbo_q;
  logic             busy_q;
  logic             stop_seen;
  logic             go_on;
  logic             cfg_ld;
  logic             frame_end;
  logic             tmr_done;

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] req,
    input logic             jumbo
  );
    logic [LEN_W-1:0] lim;
    logic [LEN_W-1:0] l;
    lim = jumbo ? LEN_W'(JUMBO_MAX)
                : LEN_W'(MAX_PAYLOAD);
    l = (req > lim) ? lim : req;
    if (l < LEN_W'(MIN_PAYLOAD))
      l = LEN_W'(MIN_PAYLOAD);
    return l;
  endfunction

  assign src_eff = src_mac_sel ? src_mac : SRC_MAC;

`ifdef FRAME_GEN_VLAN_EN
  assign hdr_d = {dst_mac, src_eff, TPID,
                  vlan_tci, ethertype};
`else
  assign hdr_d = {dst_mac, src_eff, ethertype};
`endif

  assign go_on     = cont_mode && !stop_seen && !stop;
  assign frame_end = (st == ST_HDR || st == ST_PAY) &&
                     (pos == total_q - CW'(1));
  assign cfg_ld    = (st == ST_IDLE && start) ||
                     (st == ST_GAP && tmr_done && go_on);

  assign mac.conf_tx_en         = en_q;
  assign mac.conf_tx_jumbo_en   = jumbo_q;
  assign mac.conf_tx_no_gen_crc = 1'b0;
  assign mac.mac_tx_data        = data_q;
  assign mac.mac_tx_dvld        = dvld_q;
  assign busy                   = busy_q;
  assign frame_count            = fc_q;

  frame_gen_ifg_timer #(
    .IFG_W (IFG_W)
  ) u_ifg (
    .tx_clk   (tx_clk),
    .reset_n  (reset_n),
    .load     (frame_end),
    .load_val (ifg_q),
    .en       (st == ST_GAP),
    .done     (tmr_done)
  );

  always_ff @(posedge tx_clk) begin
    if (!reset_n) begin
      hdr_q   <= '0;
      total_q <= '0;
      ifg_q   <= '0;
    end else if (cfg_ld) begin
      hdr_q   <= hdr_d;
      total_q <= CW'(clamp_len(payload_len, jumbo_en))
               + CW'(HDR_LEN);
      ifg_q   <= ifg_cycles;
    end
  end

  // Byte for position pos+1; pos is the byte now on the bus.
  always_comb begin
    nxt   = pos + CW'(1);
    pi    = nxt - CW'(HDR_LEN);
    hbyte = 8'h00;
    for (int k = 0; k < HDR_LEN; k++) begin
      if (nxt == CW'(k))
        hbyte = hdr_q[HB-1-8*k -: 8];
    end
    sbyte = seq[31:24];
    tbyte = ts_q[31:24];
    unique case (pi[1:0])
      2'd0: begin sbyte = seq[31:24]; tbyte = ts_q[31:24]; end
      2'd1: begin sbyte = seq[23:16]; tbyte = ts_q[23:16]; end
      2'd2: begin sbyte = seq[15:8];  tbyte = ts_q[15:8];  end
      2'd3: begin sbyte = seq[7:0];   tbyte = ts_q[7:0];   end
      default: ;
    endcase
    nbyte = pi[7:0];
    unique case (1'b1)
      (nxt < CW'(HDR_LEN)):            nbyte = hbyte;
      (pi < CW'(4)):                   nbyte = sbyte;
      (pi >= CW'(4) && pi < CW'(8)):   nbyte = tbyte;
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!reset_n) begin
      st        <= ST_IDLE;
      pos       <= '0;
      seq       <= '0;
      fc_q      <= '0;
      ts_q      <= '0;
      stop_seen <= 1'b0;
      busy_q    <= 1'b0;
      dvld_q    <= 1'b0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      jumbo_q   <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      jumbo_q <= jumbo_en;
      if (stop && st != ST_IDLE)
        stop_seen <= 1'b1;
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            st        <= ST_REQ;
            busy_q    <= 1'b1;
            dvld_q    <= 1'b1;
            data_q    <= dst_mac[47:40];
            pos       <= '0;
            stop_seen <= stop;
          end
        end
        ST_REQ: begin
          if (mac.mac_tx_ack) begin
            ts_q   <= timestamp;
            data_q <= nbyte;
            pos    <= nxt;
            st     <= ST_HDR;
          end
        end
        ST_HDR, ST_PAY: begin
          if (frame_end) begin
            dvld_q <= 1'b0;
            data_q <= 8'h00;
            seq    <= seq + SEQ_W'(1);
            fc_q   <= fc_q + 32'd1;
            st     <= ST_GAP;
          end else begin
            data_q <= nbyte;
            pos    <= nxt;
            st     <= (nxt < CW'(HDR_LEN)) ? ST_HDR
                                           : ST_PAY;
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            if (go_on) begin
              st     <= ST_REQ;
              dvld_q <= 1'b1;
              data_q <= dst_mac[47:40];
              pos    <= '0;
            end else begin
              st        <= ST_IDLE;
              busy_q    <= 1'b0;
              stop_seen <= 1'b0;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_gen_param.sv
// Directed and randomized bench for frame_gen_param.
// Honours FRAME_GEN_VLAN_EN for the tagged header.
module tb_frame_gen_param;

  localparam logic [47:0] SRC_DEF = 48'h004e46324300;
`ifdef FRAME_GEN_VLAN_EN
  localparam int HL = 18;
`else
  localparam int HL = 14;
`endif

  typedef struct {
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] et;
    logic [15:0] tci;
    int          len;
  } cfg_t;

  logic        tx_clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        cont_mode;
  logic        jumbo_en;
  logic [13:0] payload_len;
  logic [15:0] ifg_cycles;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic        src_mac_sel;
  logic [15:0] ethertype;
`ifdef FRAME_GEN_VLAN_EN
  logic [15:0] vlan_tci;
`endif
  logic [31:0] timestamp;
  logic        busy;
  logic [31:0] frame_count;

  frame_gen_if mac ();

  frame_gen_param dut (
    .tx_clk      (tx_clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .cont_mode   (cont_mode),
    .jumbo_en    (jumbo_en),
    .payload_len (payload_len),
    .ifg_cycles  (ifg_cycles),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .src_mac_sel (src_mac_sel),
    .ethertype   (ethertype),
`ifdef FRAME_GEN_VLAN_EN
    .vlan_tci    (vlan_tci),
`endif
    .timestamp   (timestamp),
    .mac         (mac),
    .busy        (busy),
    .frame_count (frame_count)
  );

  int errors = 0;
  int checks = 0;
  int seq_m  = 0;
  int fc_m   = 0;
  logic [7:0] exp_q[$];

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
    timestamp = $urandom;
  endtask

  function automatic int eff_len(input int req, input bit jb);
    int lim;
    int r;
    lim = jb ? 9000 : 1500;
    r = req;
    if (r > lim) r = lim;
    if (r < 46) r = 46;
    return r;
  endfunction

  function automatic cfg_t cur_cfg();
    cfg_t c;
    c.da  = dst_mac;
    c.sa  = src_mac_sel ? src_mac : SRC_DEF;
    c.et  = ethertype;
`ifdef FRAME_GEN_VLAN_EN
    c.tci = vlan_tci;
`else
    c.tci = 16'h0;
`endif
    c.len = eff_len(int'(payload_len), jumbo_en);
    return c;
  endfunction

  function automatic void build(input cfg_t c,
                                input logic [31:0] sq,
                                input logic [31:0] ts);
    exp_q.delete();
    for (int i = 0; i < 6; i++)
      exp_q.push_back(c.da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++)
      exp_q.push_back(c.sa[47-8*i -: 8]);
`ifdef FRAME_GEN_VLAN_EN
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h00);
    exp_q.push_back(c.tci[15:8]);
    exp_q.push_back(c.tci[7:0]);
`endif
    exp_q.push_back(c.et[15:8]);
    exp_q.push_back(c.et[7:0]);
    for (int i = 0; i < c.len; i++) begin
      if (i < 4)      exp_q.push_back(sq[31-8*i -: 8]);
      else if (i < 8) exp_q.push_back(ts[63-8*i -: 8]);
      else            exp_q.push_back(8'(i));
    end
  endfunction

  task automatic quiet(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (mac.mac_tx_dvld !== 1'b0) cnt++;
      tick();
    end
    chk("quiet_dvld", cnt, 0);
    chk("quiet_busy", busy, 0);
  endtask

  task automatic rx(input cfg_t c, input int ack_wait,
                    input int stop_at, input int start_at,
                    input int rst_at, input int exp_idle);
    int idle;
    int n;
    int bad;
    logic [31:0] tsv;
    idle = 0;
    bad  = 0;
    tsv  = 0;
    while (mac.mac_tx_dvld !== 1'b1 && idle < 400) begin
      idle++;
      tick();
    end
    if (mac.mac_tx_dvld !== 1'b1) begin
      chk("req_timeout", 0, 1);
      return;
    end
    if (exp_idle >= 0) chk("ifg_idle", idle, exp_idle);
    build(c, seq_m, 0);
    for (int k = 0; k < ack_wait; k++) begin
      if (mac.mac_tx_dvld !== 1'b1 ||
          mac.mac_tx_data !== exp_q[0]) bad++;
      if (k == ack_wait - 1) begin
        mac.mac_tx_ack = 1'b1;
        tsv = timestamp;
      end
      tick();
    end
    mac.mac_tx_ack = 1'b0;
    chk("hold_da", bad, 0);
    bad = 0;
    build(c, seq_m, tsv);
    n = 1;
    while (mac.mac_tx_dvld === 1'b1 &&
           n < exp_q.size() + 4) begin
      if (n >= exp_q.size() ||
          mac.mac_tx_data !== exp_q[n]) bad++;
      if (n == rst_at) begin
        chk("bytes_pre_rst", bad, 0);
        reset_n = 1'b0;
        tick();
        chk("rst_dvld", mac.mac_tx_dvld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fc", frame_count, 0);
        reset_n = 1'b1;
        seq_m = 0;
        fc_m  = 0;
        tick();
        return;
      end
      if (n == stop_at)  stop  = 1'b1;
      if (n == start_at) start = 1'b1;
      mac.mac_tx_ack = 1'($urandom);
      tick();
      stop  = 1'b0;
      start = 1'b0;
      n++;
    end
    mac.mac_tx_ack = 1'b0;
    chk("bytes", bad, 0);
    chk("len", n, exp_q.size());
    seq_m++;
    fc_m++;
    chk("frame_count", frame_count, fc_m);
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    cfg_t c;
    int   ifg;
    reset_n        = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    cont_mode      = 1'b0;
    jumbo_en       = 1'b1;
    payload_len    = 14'd100;
    ifg_cycles     = 16'd4;
    dst_mac        = 48'h0a1b2c3d4e5f;
    src_mac        = 48'h665544332211;
    src_mac_sel    = 1'b0;
    ethertype      = 16'h0800;
`ifdef FRAME_GEN_VLAN_EN
    vlan_tci       = 16'h0005;
`endif
    timestamp      = 32'h0;
    mac.mac_tx_ack = 1'b0;

    tick();
    tick();
    chk("rst_dvld0", mac.mac_tx_dvld, 0);
    chk("rst_data0", mac.mac_tx_data, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_fc0", frame_count, 0);
    chk("rst_en0", mac.conf_tx_en, 0);
    chk("rst_jumbo0", mac.conf_tx_jumbo_en, 0);
    reset_n = 1'b1;
    tick();
    chk("tx_en", mac.conf_tx_en, 1);
    chk("jumbo_cp", mac.conf_tx_jumbo_en, 1);
    chk("no_crc", mac.conf_tx_no_gen_crc, 0);
    jumbo_en = 1'b0;

    // Reset during payload byte 20, then seq restarts
    payload_len = 14'd60;
    c = cur_cfg();
    pulse_start(1'b0);
    rx(c, 2, -1, -1, HL + 20, 0);
    quiet(10);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_idle", busy, 0);

    payload_len = 14'd100;
    c = cur_cfg();
    pulse_start(1'b0);
    rx(c, 3, -1, -1, -1, 0);
    chk("len100", exp_q.size(), HL + 100);
    quiet(8);

    payload_len = 14'd10;
    c = cur_cfg();
    pulse_start(1'b0);
    rx(c, 1, -1, 30, -1, 0);
    chk("pad", exp_q.size(), HL + 46);
    quiet(8);

    payload_len = 14'd2000;
    c = cur_cfg();
    pulse_start(1'b0);
    rx(c, 2, -1, 500, -1, 0);
    chk("clamp", exp_q.size(), HL + 1500);
    quiet(8);

    jumbo_en = 1'b1;
    c = cur_cfg();
    pulse_start(1'b0);
    rx(c, 1, -1, -1, -1, 0);
    chk("jumbo", exp_q.size(), HL + 2000);
    chk("jumbo_cp1", mac.conf_tx_jumbo_en, 1);
    quiet(8);
    jumbo_en = 1'b0;

    // Continuous run, ifg 12, stopped during the third frame
    cont_mode   = 1'b1;
    ifg_cycles  = 16'd12;
    payload_len = 14'd64;
    c = cur_cfg();
    pulse_start(1'b0);
    rx(c, 2, -1, -1, -1, 0);
    payload_len = 14'd80;
    c = cur_cfg();
    rx(c, 1, -1, 20, -1, 12);
    rx(c, 3, 10, -1, -1, 12);
    quiet(40);

    ifg_cycles  = 16'd0;
    payload_len = 14'd46;
    c = cur_cfg();
    pulse_start(1'b0);
    rx(c, 1, -1, -1, -1, 0);
    rx(c, 1, 5, -1, -1, 1);
    quiet(20);

    c = cur_cfg();
    pulse_start(1'b1);
    rx(c, 1, -1, -1, -1, 0);
    quiet(30);
    cont_mode = 1'b0;

    for (int f = 0; f < 8; f++) begin
      payload_len = 14'($urandom_range(0, 2100));
      jumbo_en    = 1'($urandom);
      src_mac_sel = 1'($urandom);
      dst_mac     = {16'($urandom), 32'($urandom)};
      src_mac     = {16'($urandom), 32'($urandom)};
      ethertype   = 16'($urandom);
`ifdef FRAME_GEN_VLAN_EN
      vlan_tci    = 16'($urandom);
`endif
      ifg         = $urandom_range(0, 15);
      ifg_cycles  = 16'(ifg);
      c = cur_cfg();
      pulse_start(1'b0);
      payload_len = 14'($urandom);
      dst_mac     = {16'($urandom), 32'($urandom)};
      ethertype   = 16'($urandom);
      ifg_cycles  = 16'($urandom_range(100, 200));
      rx(c, $urandom_range(1, 4), -1, -1, -1, 0);
      quiet(ifg + 3);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
